fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL take parameter NREG, default 32: architectural register count; AW = clog2(NREG).
REQ-002 SHALL take parameter NSRC, default 2: operand ports checked per instruction.
REQ-003 SHALL take parameter NBYP, default 2: bypass stages, index 0 = youngest (EX/MEM); SW = clog2(NBYP+1).
REQ-004 SHALL take parameter MAX_PEND, default 4: maximum outstanding long-latency writes.
REQ-005 SHALL take parameter CW, default 16: stall-counter width.
REQ-006 SHALL have ports clk in 1 (clock); rst in 1 (reset, asynchronous, active-high).
REQ-007 SHALL have id_valid in 1, id_rs in NSRC*AW, id_use in NSRC, id_early in NSRC (source consumed in ID: branch/jalr), id_rd in AW, id_we in 1.
REQ-008 SHALL have ex_rs in NSRC*AW, ex_rd in AW, ex_we in 1, ex_is_load in 1.
REQ-009 SHALL have byp_rd in NBYP*AW, byp_we in NBYP, byp_rdy in NBYP (stage data forwardable).
REQ-010 SHALL have ll_issue in 1, ll_issue_rd in AW, ll_done in 1, ll_done_rd in AW.
REQ-011 SHALL have ex_fwd_sel out NSRC*SW and id_fwd_sel out NSRC*SW: 0 = register file, k = bypass stage k-1.
REQ-012 SHALL have stall out 1, bubble out 1, stall_state out 2, pend_cnt out clog2(MAX_PEND+1), cnt_lu out CW, cnt_sb out CW, err out 2.

Function
REQ-013 A source "matches" a stage when that stage's we=1, rd!=0 and rd equals the source; x0 never matches or forwards.
REQ-014 ex_fwd_sel[i] SHALL select the lowest-index matching bypass stage (youngest wins), else 0; purely combinational.
REQ-015 id_fwd_sel[i] SHALL follow the REQ-014 rule against the same stages for ID-stage sources.
REQ-016 Load-use hazard: id_valid, id_use[i], ex_we, ex_is_load, ex_rd!=0, ex_rd==id_rs[i].
REQ-017 Early hazard: id_valid, id_early[i], ex_we, ex_rd!=0, ex_rd==id_rs[i] (any EX writer), or youngest matching bypass stage has byp_rdy=0.
REQ-018 Scoreboard hazard: id_valid and (id_use[i] with sb[id_rs[i]] set, or id_we with sb[id_rd] set (WAW)).
REQ-019 Full hazard: id_valid, ll_issue-class instruction pending issue is not visible, so pend_cnt==MAX_PEND with id_we SHALL stall.
REQ-020 stall SHALL be the combinational OR of REQ-016..019; bubble SHALL equal stall.
REQ-021 Scoreboard sb[NREG] SHALL set bit ll_issue_rd on ll_issue (rd!=0) and clear ll_done_rd on ll_done, at the clock edge.
REQ-022 Simultaneous issue and done to the same register SHALL leave the bit set; to different registers, both SHALL take effect.
REQ-023 pend_cnt SHALL increment per accepted issue, decrement per accepted clear, net 0 when both accepted in one cycle.
REQ-024 ll_issue while pend_cnt==MAX_PEND or to an already-set bit SHALL be ignored and set err[0] (sticky).
REQ-025 ll_done to a clear bit SHALL be ignored and set err[1] (sticky).
REQ-026 FSM states RUN(0), LU(1), EARLY(2), SB(3); next state each cycle = highest-priority active hazard (SB > EARLY > LU), else RUN; stall_state SHALL be the registered state.
REQ-027 cnt_lu SHALL increment on cycles with load-use or early hazard; cnt_sb on scoreboard or full hazard; both saturate at all-ones.

Reset
REQ-028 On rst: sb all zero, pend_cnt 0, state RUN, cnt_lu 0, cnt_sb 0, err 0; applied immediately, asynchronously.
REQ-029 Combinational outputs SHALL reflect cleared state during reset; a mid-operation reset SHALL discard all pending entries.

Structure
REQ-030 State encodings and fwd_sel encoding (FWD_RF=0) SHALL live in the shared CPU package.
REQ-031 The scoreboard (sb, pend_cnt, err) SHALL be sub-module hazard_scoreboard; matching and FSM in the top.

Verification
REQ-032 byp0 rd=5 we=1, byp1 rd=5 we=1, ex_rs1=5 -> ex_fwd_sel[0]=1; byp0 we=0 -> 2; ex_rs1=0 -> 0.
REQ-033 ex load rd=7, id_rs2=7 id_use=1 -> stall=1 one cycle, stall_state=1 next cycle, cnt_lu=1.
REQ-034 ex ALU rd=3, id branch early rs1=3 -> stall=1; next cycle byp0 rd=3 rdy=1 -> stall=0, id_fwd_sel[0]=1.
REQ-035 ll_issue rd=9; id_rs1=9 -> stall until ll_done rd=9, then stall=0, pend_cnt 1->0, cnt_sb = wait cycles.
REQ-036 Issue rd=1..4 (MAX_PEND=4), fifth issue -> ignored, err[0]=1; ll_done rd=20 -> err[1]=1.
REQ-037 ll_issue and ll_done same rd=6 same cycle -> sb[6]=1, pend_cnt unchanged; rst mid-wait -> stall=0, pend_cnt=0.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared CPU pipeline definitions: hazard FSM state encoding, forward-select
// codes and the hazard-priority helper used by the forwarding/hazard unit.
package fwd_hazard_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LU    = 2'd1,
        ST_EARLY = 2'd2,
        ST_SB    = 2'd3
    } hazard_state_t;

    // Forward-select value meaning "take the operand from the register file";
    // value k selects bypass stage k-1.
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic lu;
        logic early;
        logic sb;
        logic full;
    } hazard_vec_t;

    // Scoreboard/full stalls outrank early-use stalls, which outrank load-use.
    function automatic hazard_state_t next_hazard_state(input hazard_vec_t h);
        if (h.sb || h.full) begin
            return ST_SB;
        end
        if (h.early) begin
            return ST_EARLY;
        end
        if (h.lu) begin
            return ST_LU;
        end
        return ST_RUN;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy-register scoreboard for long-latency writers: tracks outstanding
// destinations, the number in flight, and sticky protocol-violation flags.
module hazard_scoreboard
    import fwd_hazard_unit_pkg::*;
#(
    parameter int  NREG     = 32,
    parameter int  MAX_PEND = 4,
    localparam int AW       = $clog2(NREG),
    localparam int PW       = $clog2(MAX_PEND + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_issue,
    input  logic [AW-1:0]   i_issue_rd,
    input  logic            i_done,
    input  logic [AW-1:0]   i_done_rd,
    output logic [NREG-1:0] o_sb,
    output logic [PW-1:0]   o_pend_cnt,
    output logic [1:0]      o_err
);

    logic [NREG-1:0] r_sb;
    logic [PW-1:0]   r_pend_cnt;
    logic [1:0]      r_err;

    logic w_done_ok;
    logic w_same_rd;
    logic w_room;
    logic w_issue_ok;
    logic w_issue_err;
    logic w_done_err;

    // A retire frees both its slot and its bit in the same cycle, so a
    // same-cycle issue may reuse them (retire-and-reissue keeps the bit set).
    always_comb begin
        w_done_ok   = i_done && r_sb[i_done_rd];
        w_same_rd   = w_done_ok && (i_done_rd == i_issue_rd);
        w_room      = (r_pend_cnt != PW'(MAX_PEND)) || w_done_ok;
        w_issue_ok  = i_issue && (i_issue_rd != '0) && w_room &&
                      (!r_sb[i_issue_rd] || w_same_rd);
        w_issue_err = i_issue && (i_issue_rd != '0) && !w_issue_ok;
        w_done_err  = i_done && !w_done_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb       <= '0;
            r_pend_cnt <= '0;
            r_err      <= '0;
        end else begin
            if (w_done_ok) begin
                r_sb[i_done_rd] <= 1'b0;
            end
            if (w_issue_ok) begin
                r_sb[i_issue_rd] <= 1'b1;
            end
            if (w_issue_ok && !w_done_ok) begin
                r_pend_cnt <= r_pend_cnt + PW'(1);
            end else if (!w_issue_ok && w_done_ok) begin
                r_pend_cnt <= r_pend_cnt - PW'(1);
            end
            r_err <= r_err | {w_done_err, w_issue_err};
        end
    end

    assign o_sb       = r_sb;
    assign o_pend_cnt = r_pend_cnt;
    assign o_err      = r_err;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selection and pipeline stall generation (load-use,
// early ID-stage use, long-latency scoreboard) with a hazard-class FSM.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int  NREG     = 32,
    parameter int  NSRC     = 2,
    parameter int  NBYP     = 2,
    parameter int  MAX_PEND = 4,
    parameter int  CW       = 16,
    localparam int AW       = $clog2(NREG),
    localparam int SW       = $clog2(NBYP + 1),
    localparam int PW       = $clog2(MAX_PEND + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [NSRC*AW-1:0] id_rs,
    input  logic [NSRC-1:0]    id_use,
    input  logic [NSRC-1:0]    id_early,
    input  logic [AW-1:0]      id_rd,
    input  logic               id_we,
    input  logic [NSRC*AW-1:0] ex_rs,
    input  logic [AW-1:0]      ex_rd,
    input  logic               ex_we,
    input  logic               ex_is_load,
    input  logic [NBYP*AW-1:0] byp_rd,
    input  logic [NBYP-1:0]    byp_we,
    input  logic [NBYP-1:0]    byp_rdy,
    input  logic               ll_issue,
    input  logic [AW-1:0]      ll_issue_rd,
    input  logic               ll_done,
    input  logic [AW-1:0]      ll_done_rd,
    output logic [NSRC*SW-1:0] ex_fwd_sel,
    output logic [NSRC*SW-1:0] id_fwd_sel,
    output logic               stall,
    output logic               bubble,
    output logic [1:0]         stall_state,
    output logic [PW-1:0]      pend_cnt,
    output logic [CW-1:0]      cnt_lu,
    output logic [CW-1:0]      cnt_sb,
    output logic [1:0]         err
);

    logic [NREG-1:0] w_sb;
    logic [PW-1:0]   w_pend_cnt;
    hazard_vec_t     w_haz;
    logic [AW-1:0]   w_ex_src;
    logic [AW-1:0]   w_id_src;
    logic [AW-1:0]   w_byp_rd;
    logic [SW-1:0]   w_ex_sel;
    logic [SW-1:0]   w_id_sel;
    logic            w_id_hit;
    logic            w_id_rdy;
    logic            w_ex_hit;

    hazard_state_t   r_state;
    logic [CW-1:0]   r_cnt_lu;
    logic [CW-1:0]   r_cnt_sb;

    hazard_scoreboard #(
        .NREG     (NREG),
        .MAX_PEND (MAX_PEND)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_issue    (ll_issue),
        .i_issue_rd (ll_issue_rd),
        .i_done     (ll_done),
        .i_done_rd  (ll_done_rd),
        .o_sb       (w_sb),
        .o_pend_cnt (w_pend_cnt),
        .o_err      (err)
    );

    always_comb begin
        ex_fwd_sel = '0;
        id_fwd_sel = '0;
        w_haz      = '0;
        w_ex_src   = '0;
        w_id_src   = '0;
        w_byp_rd   = '0;
        w_ex_sel   = SW'(FWD_RF);
        w_id_sel   = SW'(FWD_RF);
        w_id_hit   = 1'b0;
        w_id_rdy   = 1'b1;
        w_ex_hit   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            w_ex_src = ex_rs[i*AW +: AW];
            w_id_src = id_rs[i*AW +: AW];
            w_ex_sel = SW'(FWD_RF);
            w_id_sel = SW'(FWD_RF);
            w_id_hit = 1'b0;
            w_id_rdy = 1'b1;
            // Walk oldest to youngest so the youngest matching stage wins.
            for (int k = NBYP - 1; k >= 0; k--) begin
                w_byp_rd = byp_rd[k*AW +: AW];
                if (byp_we[k] && (w_byp_rd != '0) && (w_byp_rd == w_ex_src)) begin
                    w_ex_sel = SW'(k + 1);
                end
                if (byp_we[k] && (w_byp_rd != '0) && (w_byp_rd == w_id_src)) begin
                    w_id_sel = SW'(k + 1);
                    w_id_hit = 1'b1;
                    w_id_rdy = byp_rdy[k];
                end
            end
            ex_fwd_sel[i*SW +: SW] = w_ex_sel;
            id_fwd_sel[i*SW +: SW] = w_id_sel;

            w_ex_hit = ex_we && (ex_rd != '0) && (ex_rd == w_id_src);
            if (id_valid && id_use[i] && ex_is_load && w_ex_hit) begin
                w_haz.lu = 1'b1;
            end
            if (id_valid && id_early[i] && (w_ex_hit || (w_id_hit && !w_id_rdy))) begin
                w_haz.early = 1'b1;
            end
            if (id_valid && id_use[i] && w_sb[w_id_src]) begin
                w_haz.sb = 1'b1;
            end
        end
        if (id_valid && id_we && w_sb[id_rd]) begin
            w_haz.sb = 1'b1;
        end
        // A new long-latency write cannot be told apart in ID, so any writer waits when full.
        w_haz.full = id_valid && id_we && (w_pend_cnt == PW'(MAX_PEND));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_cnt_lu <= '0;
            r_cnt_sb <= '0;
        end else begin
            r_state <= next_hazard_state(w_haz);
            if ((w_haz.lu || w_haz.early) && (r_cnt_lu != '1)) begin
                r_cnt_lu <= r_cnt_lu + CW'(1);
            end
            if ((w_haz.sb || w_haz.full) && (r_cnt_sb != '1)) begin
                r_cnt_sb <= r_cnt_sb + CW'(1);
            end
        end
    end

    assign stall       = w_haz.lu | w_haz.early | w_haz.sb | w_haz.full;
    assign bubble      = stall;
    assign stall_state = r_state;
    assign pend_cnt    = w_pend_cnt;
    assign cnt_lu      = r_cnt_lu;
    assign cnt_sb      = r_cnt_sb;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_fwd_hazard_unit;

    localparam int NREG     = 32;
    localparam int NSRC     = 2;
    localparam int NBYP     = 2;
    localparam int MAX_PEND = 4;
    localparam int CW       = 16;
    localparam int AW       = 5;
    localparam int SW       = 2;
    localparam int PW       = 3;
    localparam int CNT_MAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;

    logic               id_valid;
    logic [NSRC*AW-1:0] id_rs;
    logic [NSRC-1:0]    id_use;
    logic [NSRC-1:0]    id_early;
    logic [AW-1:0]      id_rd;
    logic               id_we;
    logic [NSRC*AW-1:0] ex_rs;
    logic [AW-1:0]      ex_rd;
    logic               ex_we;
    logic               ex_is_load;
    logic [NBYP*AW-1:0] byp_rd;
    logic [NBYP-1:0]    byp_we;
    logic [NBYP-1:0]    byp_rdy;
    logic               ll_issue;
    logic [AW-1:0]      ll_issue_rd;
    logic               ll_done;
    logic [AW-1:0]      ll_done_rd;
    logic [NSRC*SW-1:0] ex_fwd_sel;
    logic [NSRC*SW-1:0] id_fwd_sel;
    logic               stall;
    logic               bubble;
    logic [1:0]         stall_state;
    logic [PW-1:0]      pend_cnt;
    logic [CW-1:0]      cnt_lu;
    logic [CW-1:0]      cnt_sb;
    logic [1:0]         err;

    // Bench-side stimulus, kept as plain integers per source/stage.
    bit idValid;
    int idRs[NSRC];
    bit idUse[NSRC];
    bit idEarly[NSRC];
    int idRd;
    bit idWe;
    int exRs[NSRC];
    int exRd;
    bit exWe;
    bit exLoad;
    int bypRd[NBYP];
    bit bypWe[NBYP];
    bit bypRdy[NBYP];
    bit llIssue;
    int llIssueRd;
    bit llDone;
    int llDoneRd;

    // Reference model state.
    bit mSb[NREG];
    int mPend;
    int mState;
    int mCntLu;
    int mCntSb;
    int mErr;
    bit hLu, hEarly, hSb, hFull;

    int nCompared   = 0;
    int nMismatched = 0;

    fwd_hazard_unit #(
        .NREG     (NREG),
        .NSRC     (NSRC),
        .NBYP     (NBYP),
        .MAX_PEND (MAX_PEND),
        .CW       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_use      (id_use),
        .id_early    (id_early),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .ex_rs       (ex_rs),
        .ex_rd       (ex_rd),
        .ex_we       (ex_we),
        .ex_is_load  (ex_is_load),
        .byp_rd      (byp_rd),
        .byp_we      (byp_we),
        .byp_rdy     (byp_rdy),
        .ll_issue    (ll_issue),
        .ll_issue_rd (ll_issue_rd),
        .ll_done     (ll_done),
        .ll_done_rd  (ll_done_rd),
        .ex_fwd_sel  (ex_fwd_sel),
        .id_fwd_sel  (id_fwd_sel),
        .stall       (stall),
        .bubble      (bubble),
        .stall_state (stall_state),
        .pend_cnt    (pend_cnt),
        .cnt_lu      (cnt_lu),
        .cnt_sb      (cnt_sb),
        .err         (err)
    );

    always #5 clk = ~clk;

    always_comb begin
        id_rs    = '0;
        ex_rs    = '0;
        id_use   = '0;
        id_early = '0;
        byp_rd   = '0;
        byp_we   = '0;
        byp_rdy  = '0;
        for (int i = 0; i < NSRC; i++) begin
            id_rs[i*AW +: AW] = AW'(idRs[i]);
            ex_rs[i*AW +: AW] = AW'(exRs[i]);
            id_use[i]         = idUse[i];
            id_early[i]       = idEarly[i];
        end
        for (int k = 0; k < NBYP; k++) begin
            byp_rd[k*AW +: AW] = AW'(bypRd[k]);
            byp_we[k]          = bypWe[k];
            byp_rdy[k]         = bypRdy[k];
        end
        id_valid    = idValid;
        id_rd       = AW'(idRd);
        id_we       = idWe;
        ex_rd       = AW'(exRd);
        ex_we       = exWe;
        ex_is_load  = exLoad;
        ll_issue    = llIssue;
        ll_issue_rd = AW'(llIssueRd);
        ll_done     = llDone;
        ll_done_rd  = AW'(llDoneRd);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compareVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Youngest producer wins: scan stages from youngest; x0 never forwards.
    function automatic int bypSel(input int src);
        if (src == 0) return 0;
        for (int k = 0; k < NBYP; k++) begin
            if (bypWe[k] && bypRd[k] == src) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit exWrites(input int src);
        return exWe && exRd != 0 && exRd == src;
    endfunction

    task automatic evalHazards();
        int sel;
        hLu    = 0;
        hEarly = 0;
        hSb    = 0;
        hFull  = 0;
        if (idValid) begin
            for (int i = 0; i < NSRC; i++) begin
                sel = bypSel(idRs[i]);
                if (idUse[i] && exLoad && exWrites(idRs[i])) hLu = 1;
                if (idEarly[i] && (exWrites(idRs[i]) || (sel != 0 && !bypRdy[sel-1]))) hEarly = 1;
                if (idUse[i] && mSb[idRs[i]]) hSb = 1;
            end
            if (idWe && mSb[idRd]) hSb = 1;
            if (idWe && mPend == MAX_PEND) hFull = 1;
        end
    endtask

    task automatic modelReset();
        foreach (mSb[r]) mSb[r] = 0;
        mPend  = 0;
        mState = 0;
        mCntLu = 0;
        mCntSb = 0;
        mErr   = 0;
    endtask

    task automatic clearInputs();
        idValid = 0; idRd = 0; idWe = 0;
        exRd = 0; exWe = 0; exLoad = 0;
        llIssue = 0; llIssueRd = 0; llDone = 0; llDoneRd = 0;
        for (int i = 0; i < NSRC; i++) begin
            idRs[i] = 0; idUse[i] = 0; idEarly[i] = 0; exRs[i] = 0;
        end
        for (int k = 0; k < NBYP; k++) begin
            bypRd[k] = 0; bypWe[k] = 0; bypRdy[k] = 0;
        end
    endtask

    task automatic checkOutput();
        bit anyStall;
        evalHazards();
        anyStall = hLu || hEarly || hSb || hFull;
        for (int i = 0; i < NSRC; i++) begin
            compareVal($sformatf("ex_fwd_sel%0d", i), 32'(ex_fwd_sel[i*SW +: SW]), bypSel(exRs[i]));
            compareVal($sformatf("id_fwd_sel%0d", i), 32'(id_fwd_sel[i*SW +: SW]), bypSel(idRs[i]));
        end
        compareVal("stall", 32'(stall), 32'(anyStall));
        compareVal("bubble", 32'(bubble), 32'(anyStall));
        compareVal("stall_state", 32'(stall_state), mState);
        compareVal("pend_cnt", 32'(pend_cnt), mPend);
        compareVal("cnt_lu", 32'(cnt_lu), mCntLu);
        compareVal("cnt_sb", 32'(cnt_sb), mCntSb);
        compareVal("err", 32'(err), mErr);
    endtask

    // Check the current cycle, then advance DUT and model across one edge.
    task automatic stepCycle();
        int  nextState;
        bit  doneOk, issueOk, issueErr, doneErr;
        #1;
        checkOutput();
        if (hSb || hFull)  nextState = 3;
        else if (hEarly)   nextState = 2;
        else if (hLu)      nextState = 1;
        else               nextState = 0;
        doneOk   = llDone && mSb[llDoneRd];
        issueOk  = llIssue && llIssueRd != 0 && (mPend < MAX_PEND || doneOk) &&
                   (!mSb[llIssueRd] || (doneOk && llDoneRd == llIssueRd));
        issueErr = llIssue && llIssueRd != 0 && !issueOk;
        doneErr  = llDone && !doneOk;
        @(posedge clk);
        #1;
        mState = nextState;
        if ((hLu || hEarly) && mCntLu < CNT_MAX) mCntLu++;
        if ((hSb || hFull) && mCntSb < CNT_MAX) mCntSb++;
        if (doneOk)  mSb[llDoneRd] = 0;
        if (issueOk) mSb[llIssueRd] = 1;
        mPend = mPend + int'(issueOk) - int'(doneOk);
        if (issueErr) mErr = mErr | 1;
        if (doneErr)  mErr = mErr | 2;
    endtask

    task automatic doReset();
        rst = 1;
        #1;
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic applyStimulus();
        idValid = ($urandom_range(0, 3) != 0);
        idRd    = $urandom_range(0, 7);
        idWe    = $urandom_range(0, 1);
        exRd    = $urandom_range(0, 7);
        exWe    = $urandom_range(0, 1);
        exLoad  = $urandom_range(0, 1);
        for (int i = 0; i < NSRC; i++) begin
            idRs[i]    = $urandom_range(0, 7);
            exRs[i]    = $urandom_range(0, 7);
            idUse[i]   = $urandom_range(0, 1);
            idEarly[i] = ($urandom_range(0, 3) == 0);
        end
        for (int k = 0; k < NBYP; k++) begin
            bypRd[k]  = $urandom_range(0, 7);
            bypWe[k]  = $urandom_range(0, 1);
            bypRdy[k] = ($urandom_range(0, 3) != 0);
        end
        llIssue   = ($urandom_range(0, 2) == 0);
        llIssueRd = $urandom_range(0, 7);
        llDone    = ($urandom_range(0, 2) == 0);
        llDoneRd  = $urandom_range(1, 7);
    endtask

    initial begin
        rst = 1;
        clearInputs();
        modelReset();
        @(posedge clk);
        #1;
        checkOutput();
        rst = 0;

        // Youngest bypass stage wins; x0 never forwards.
        bypRd[0] = 5; bypWe[0] = 1; bypRd[1] = 5; bypWe[1] = 1; exRs[0] = 5;
        #1 compareVal("fwd_youngest", 32'(ex_fwd_sel[1:0]), 1);
        stepCycle();
        bypWe[0] = 0;
        #1 compareVal("fwd_older", 32'(ex_fwd_sel[1:0]), 2);
        stepCycle();
        exRs[0] = 0;
        #1 compareVal("fwd_x0", 32'(ex_fwd_sel[1:0]), 0);
        stepCycle();

        // Load-use on the second source.
        clearInputs();
        exRd = 7; exWe = 1; exLoad = 1; idValid = 1; idRs[1] = 7; idUse[1] = 1;
        #1 compareVal("lu_stall", 32'(stall), 1);
        stepCycle();
        clearInputs();
        #1 compareVal("lu_state", 32'(stall_state), 1);
        compareVal("lu_cnt", 32'(cnt_lu), 1);
        compareVal("lu_release", 32'(stall), 0);
        stepCycle();

        // Branch needs an EX result in ID, then picks it up from EX/MEM.
        exRd = 3; exWe = 1; idValid = 1; idRs[0] = 3; idEarly[0] = 1;
        #1 compareVal("early_stall", 32'(stall), 1);
        stepCycle();
        exWe = 0; bypRd[0] = 3; bypWe[0] = 1; bypRdy[0] = 1;
        #1 compareVal("early_release", 32'(stall), 0);
        compareVal("early_idsel", 32'(id_fwd_sel[1:0]), 1);
        stepCycle();

        // Scoreboard wait on a long-latency result.
        clearInputs();
        llIssue = 1; llIssueRd = 9;
        stepCycle();
        llIssue = 0; idValid = 1; idRs[0] = 9; idUse[0] = 1;
        #1 compareVal("sb_pend1", 32'(pend_cnt), 1);
        repeat (3) begin
            #1 compareVal("sb_wait", 32'(stall), 1);
            stepCycle();
        end
        llDone = 1; llDoneRd = 9;
        #1 compareVal("sb_done_cycle", 32'(stall), 1);
        stepCycle();
        llDone = 0;
        #1 compareVal("sb_release", 32'(stall), 0);
        compareVal("sb_pend0", 32'(pend_cnt), 0);
        compareVal("sb_cnt", 32'(cnt_sb), 4);
        stepCycle();

        // Capacity and protocol errors.
        clearInputs();
        for (int r = 1; r <= 5; r++) begin
            llIssue = 1; llIssueRd = r;
            stepCycle();
        end
        llIssue = 0;
        #1 compareVal("full_err0", 32'(err), 1);
        compareVal("full_pend", 32'(pend_cnt), MAX_PEND);
        llDone = 1; llDoneRd = 20;
        stepCycle();
        llDone = 0;
        #1 compareVal("done_err1", 32'(err), 3);
        doReset();

        // Retire-and-reissue of the same register, then reset mid-wait.
        llIssue = 1; llIssueRd = 6;
        stepCycle();
        llDone = 1; llDoneRd = 6;
        stepCycle();
        clearInputs();
        idValid = 1; idRs[0] = 6; idUse[0] = 1;
        #1 compareVal("reissue_pend", 32'(pend_cnt), 1);
        compareVal("reissue_busy", 32'(stall), 1);
        compareVal("reissue_err", 32'(err), 0);
        stepCycle();
        rst = 1;
        #1;
        modelReset();
        compareVal("rst_stall", 32'(stall), 0);
        compareVal("rst_pend", 32'(pend_cnt), 0);
        checkOutput();
        @(posedge clk);
        #1;
        rst = 0;

        // Randomized traffic with periodic mid-run resets.
        for (int blk = 0; blk < 3; blk++) begin
            for (int n = 0; n < 150; n++) begin
                applyStimulus();
                stepCycle();
            end
            applyStimulus();
            doReset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
